u_pcoin: RTL and testbench
==========================

# u_pcoin

Single-block SHA-256 hashing engine with a serial (SPI-style) host interface. A host shifts in one pre-padded 512-bit message block, the core runs the 64 SHA-256 compression rounds in the system clock domain, raises `done`, and the host shifts out the 256-bit digest. It is the hashing core of the uPcoin miner, sitting between the microcontroller SPI link and the mining control logic.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sck`  input  1  serial clock from host; sampled in the `clk` domain.
- `sdi`  input  1  serial data in, MSB first.
- `sdo`  output  1  serial data out (digest), MSB first.
- `block_load`  input  1  high while a block is being loaded; when high at start of hashing, chaining value is initialised to the SHA-256 IV.
- `message_load`  input  1  high while the host shifts message bits in; its falling edge starts hashing.
- `done`  output  1  digest valid and ready to shift out.

## Operation
- `sck`, `sdi`, `block_load`, `message_load` pass through 2-flop synchronisers; `sck` rising/falling edges are detected in the `clk` domain.
- LOAD (`message_load` high): on each `sck` rising edge, `msg <= {msg[510:0], sdi}`. After 512 edges `msg[511]` holds the first bit sent. No bit counter enforced; extra bits shift older bits out.
- Message is already padded by the host (e.g. "abc" = `0x616263 80 00…00 18`); core does no padding.
- `message_load` falling edge: if `block_load` high, H0..H7 <= SHA-256 IV (`6a09e667 … 5be0cd19`); otherwise H keeps previous digest (chaining). a..h <= H; W window <= msg (W0 = `msg[511:480]`). Enter HASH.
- HASH: 64 rounds, one per `clk`, round t uses K[t] and W[t]; W[t≥16] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16] mod 2^32, computed from a 16-word sliding window. All adds mod 2^32.
- FINAL: Hi <= Hi + working var i (mod 2^32); digest = {H0..H7}, H0 most significant. Load output shift register with digest; `done` <= 1. Enter DONE.
- DONE: `sdo` = `out[255]`; on each `sck` falling edge `out <= {out[254:0], 1'b0}`. After 256 shifts `sdo` = 0. `sck` rising edges in DONE do not alter `msg`.
- `message_load` rising edge in any state: `done` <= 0, return to LOAD (reloads message; aborts a hash in progress).
- States: LOAD -> HASH (load fall) -> FINAL (after round 63) -> DONE -> LOAD (load rise).

## Timing
- Reset values: `done` = 0, `sdo` = 0, state = LOAD, msg = 0, H = IV, out = 0.
- Reset mid-hash or mid-shift-out: abort, reset values next cycle.
- Host rule: `sck` high and low each ≥ 3 `clk` periods; `sdi` stable across the `sck` rising edge synchroniser window.
- Latency: `done` rises 66 `clk` cycles (±2 for synchroniser) after the synchronised `message_load` fall.
- First digest bit (`H0[31]`) on `sdo` in the same cycle `done` rises, i.e. before the first `sck` rise; host samples `sdo` after each `sck` rise, bit k valid until the k-th `sck` fall.
- `done` stays high until `message_load` rises or `reset`.

## Test plan
- Reset: assert `reset` 2 cycles -> `done`=0, `sdo`=0.
- "abc" block `61626380 00…00 00000018`, `block_load`=1 -> 256 bits shifted out = `ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad`; `done` within 70 clk of load fall.
- Empty message block `80000000 00…00` -> `e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855`.
- `reset` asserted during round ~30 of "abc" -> `done` stays 0; reload "abc" -> correct digest.
- `message_load` reasserted while DONE -> `done` drops next sync'd cycle; new empty-block load yields empty-string digest.
- Extra `sck` pulses after 256 output bits -> `sdo`=0; `sck` pulses while HASH do not corrupt digest.

Source files
------------

// File: rtl/u_pcoin_if.sv
// ---------------------------------------------------------------------------
// u_pcoin_if
// Serial host link of the u_pcoin SHA-256 core.
//   sck          host serial clock (asynchronous to clk)
//   sdi          serial message data in, MSB first
//   sdo          serial digest data out, MSB first
//   block_load   high while a fresh (IV-initialised) block is being loaded
//   message_load high while message bits are shifted in; fall starts hashing
//   done         digest valid and ready to shift out
// The host drives through the master modport, the core uses the slave one.
// ---------------------------------------------------------------------------
interface u_pcoin_if;
    logic sck;
    logic sdi;
    logic sdo;
    logic block_load;
    logic message_load;
    logic done;

    modport master (
        output sck,
        output sdi,
        output block_load,
        output message_load,
        input  sdo,
        input  done
    );

    modport slave (
        input  sck,
        input  sdi,
        input  block_load,
        input  message_load,
        output sdo,
        output done
    );
endinterface

// File: rtl/u_pcoin.sv
// ---------------------------------------------------------------------------
// u_pcoin
// Single-block SHA-256 engine with an SPI-style host link. The host shifts a
// pre-padded 512-bit block in, the core runs 64 rounds (one per clk), raises
// done, and the host shifts the 256-bit digest out on sck falling edges.
//   clk    system clock, all state on its rising edge
//   reset  synchronous, active-high
//   bus    u_pcoin_if.slave: sck, sdi, block_load, message_load in;
//          sdo, done out
// ---------------------------------------------------------------------------
module u_pcoin (
    input  logic         clk,
    input  logic         reset,
    u_pcoin_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_HASH  = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Synchronisers; the third stage of sck and message_load is the
    // "previous" value used for edge detection.
    logic [2:0] r_sck_sync;
    logic [2:0] r_ml_sync;
    logic [1:0] r_sdi_sync;
    logic [1:0] r_bl_sync;

    logic w_sck_rise, w_sck_fall, w_ml_rise, w_ml_fall;
    logic w_ml, w_sdi, w_bl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_sync <= '0;
            r_ml_sync  <= '0;
            r_sdi_sync <= '0;
            r_bl_sync  <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[1:0], bus.sck};
            r_ml_sync  <= {r_ml_sync[1:0], bus.message_load};
            r_sdi_sync <= {r_sdi_sync[0], bus.sdi};
            r_bl_sync  <= {r_bl_sync[0], bus.block_load};
        end
    end

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_ml_rise  = r_ml_sync[1] & ~r_ml_sync[2];
    assign w_ml_fall  = ~r_ml_sync[1] & r_ml_sync[2];
    assign w_ml       = r_ml_sync[1];
    assign w_sdi      = r_sdi_sync[1];
    assign w_bl       = r_bl_sync[1];

    // ---------------------------------------------------------------- FSM
    state_t r_state, w_state_nxt;
    logic [5:0] r_round;

    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses <= so all flops sample the
        // pre-edge values regardless of statement order.
        if (reset) r_state <= ST_LOAD;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path leaves w_state_nxt unassigned and
        // no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_LOAD:  if (w_ml_fall) w_state_nxt = ST_HASH;
            ST_HASH:  if (r_round == 6'd63) w_state_nxt = ST_FINAL;
            ST_FINAL: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_LOAD;
        endcase
        // A new message_load rise aborts whatever is going on.
        if (w_ml_rise) w_state_nxt = ST_LOAD;
    end

    // ------------------------------------------------------------ datapath
    logic [511:0] r_msg;
    logic [31:0]  r_h [8];     // chaining value H0..H7
    logic [31:0]  r_v [8];     // working variables a..h (index 0 = a)
    logic [31:0]  r_w [16];    // r_w[j] holds W[t+j] during round t
    logic [255:0] r_out;
    logic         r_done;

    logic [31:0]  w_t1, w_t2, w_w_new;
    logic [255:0] w_digest;

    always_comb begin
        w_t1 = r_v[7] + big_sig1(r_v[4])
             + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]))
             + K_TAB[r_round] + r_w[0];
        w_t2 = big_sig0(r_v[0])
             + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
        // Next schedule word W[t+16] from the sliding window.
        w_w_new = small_sig1(r_w[14]) + r_w[9] + small_sig0(r_w[1]) + r_w[0];
        w_digest = '0;
        for (int i = 0; i < 8; i++) begin
            w_digest[255 - 32*i -: 32] = r_h[i] + r_v[i];
        end
    end

    // Control-visible state with reset values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_msg   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_round <= '0;
            for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (w_ml && w_sck_rise) r_msg <= {r_msg[510:0], w_sdi};
                    if (w_ml_fall) begin
                        r_round <= '0;
                        if (w_bl) for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
                    end
                end
                ST_HASH:  r_round <= r_round + 6'd1;
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) r_h[i] <= w_digest[255 - 32*i -: 32];
                    r_out  <= w_digest;
                    r_done <= 1'b1;
                end
                ST_DONE:  if (w_sck_fall) r_out <= {r_out[254:0], 1'b0};
                default:  ;
            endcase
            // Placed last so an abort wins over a simultaneous FINAL.
            if (w_ml_rise) r_done <= 1'b0;
        end
    end

    // Round pipeline state. It is always fully loaded from H and msg before
    // use, so it carries no reset.
    always_ff @(posedge clk) begin
        // NOTE: the working variables and schedule window are deliberately
        // not reset: they are overwritten at hash start and never observed
        // before that, so a reset would only add fan-out.
        if (r_state == ST_LOAD && w_ml_fall) begin
            for (int i = 0; i < 8; i++)  r_v[i] <= w_bl ? IV[i] : r_h[i];
            for (int i = 0; i < 16; i++) r_w[i] <= r_msg[511 - 32*i -: 32];
        end else if (r_state == ST_HASH) begin
            r_v[0] <= w_t1 + w_t2;
            r_v[1] <= r_v[0];
            r_v[2] <= r_v[1];
            r_v[3] <= r_v[2];
            r_v[4] <= r_v[3] + w_t1;
            r_v[5] <= r_v[4];
            r_v[6] <= r_v[5];
            r_v[7] <= r_v[6];
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_w_new;
        end
    end

    // First digest bit appears together with done; zero otherwise.
    assign bus.sdo  = r_done & r_out[255];
    assign bus.done = r_done;

endmodule

// File: tb/tb_u_pcoin.sv
// ---------------------------------------------------------------------------
// tb_u_pcoin
// Self-checking bench for u_pcoin: drives the serial host protocol and
// compares shifted-out digests against known SHA-256 vectors and a
// behavioural SHA-256 model that tracks the chaining value.
// ---------------------------------------------------------------------------
module tb_u_pcoin;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    u_pcoin_if bus ();

    u_pcoin dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [255:0] IV_H =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

    localparam logic [31:0] K_REF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------ reference SHA-256
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One compression of a 512-bit block starting from chaining value hin.
    function automatic logic [255:0] sha_ref(input logic [511:0] blk, input logic [255:0] hin);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = blk[511 - 32*t -: 32];
            end else begin
                s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_REF[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    // ------------------------------------------------ host-side helpers
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_pulse();
        bus.sck = 1'b1;
        wait_clk(4);
        bus.sck = 1'b0;
        wait_clk(4);
    endtask

    // Shift a block in MSB first and drop message_load to start hashing.
    task automatic send_block(input logic [511:0] blk, input logic bl);
        bus.block_load   = bl;
        bus.message_load = 1'b1;
        wait_clk(6);
        for (int i = 511; i >= 0; i--) begin
            bus.sdi = blk[i];
            wait_clk(4);
            bus.sck = 1'b1;
            wait_clk(4);
            bus.sck = 1'b0;
        end
        wait_clk(4);
        bus.message_load = 1'b0;
    endtask

    // Cycles from the message_load drop until done, bounded.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 120) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.done, 1'b1);
    endtask

    // Host samples sdo after each sck rise; the core shifts on the fall.
    task automatic read_digest(output logic [255:0] d);
        for (int k = 0; k < 256; k++) begin
            bus.sck = 1'b1;
            wait_clk(4);
            d[255 - k] = bus.sdo;
            bus.sck = 1'b0;
            wait_clk(4);
        end
    endtask

    logic [255:0] model_h;
    logic [255:0] exp_d, got_d;
    logic [511:0] blk;
    int           lat;
    logic         seen_done;

    initial begin
        reset            = 1'b1;
        bus.sck          = 1'b0;
        bus.sdi          = 1'b0;
        bus.block_load   = 1'b0;
        bus.message_load = 1'b0;
        model_h          = IV_H;

        // Reset state.
        wait_clk(2);
        check("reset_done", bus.done, 1'b0);
        check("reset_sdo", bus.sdo, 1'b0);
        reset = 1'b0;
        wait_clk(3);
        check("idle_done", bus.done, 1'b0);

        // "abc" with IV, including latency and first-bit timing.
        send_block(ABC_BLK, 1'b1);
        wait_done("abc_done", lat);
        check("abc_latency_in_range", (lat >= 64 && lat <= 72), 1'b1);
        check("abc_first_bit", bus.sdo, ABC_DIGEST[255]);
        read_digest(got_d);
        check("abc_digest", got_d, ABC_DIGEST);
        model_h = ABC_DIGEST;
        for (int p = 0; p < 4; p++) begin
            sck_pulse();
            check("extra_sck_sdo_zero", bus.sdo, 1'b0);
        end
        check("done_held", bus.done, 1'b1);
        bus.block_load = 1'b0;

        // Empty-string block.
        send_block(EMPTY_BLK, 1'b1);
        wait_done("empty_done", lat);
        read_digest(got_d);
        check("empty_digest", got_d, EMPTY_DIGEST);
        model_h = EMPTY_DIGEST;

        // Reset around round 30 of "abc": nothing may complete.
        send_block(ABC_BLK, 1'b1);
        wait_clk(32);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        model_h = IV_H;
        seen_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 1'b0);
        check("abort_sdo", bus.sdo, 1'b0);

        // Reload "abc" after the abort.
        send_block(ABC_BLK, 1'b1);
        wait_done("reload_done", lat);
        read_digest(got_d);
        check("reload_digest", got_d, ABC_DIGEST);
        model_h = ABC_DIGEST;

        // message_load rise while DONE drops done, then an empty block.
        bus.message_load = 1'b1;
        wait_clk(4);
        check("reassert_done_low", bus.done, 1'b0);
        check("reassert_sdo_low", bus.sdo, 1'b0);
        send_block(EMPTY_BLK, 1'b1);
        wait_done("reassert_empty_done", lat);
        read_digest(got_d);
        check("reassert_empty_digest", got_d, EMPTY_DIGEST);
        model_h = EMPTY_DIGEST;

        // Random blocks: a fresh block with sck noise during hashing,
        // followed by a chained block without block_load.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom();
            exp_d = sha_ref(blk, IV_H);
            send_block(blk, 1'b1);
            for (int p = 0; p < 3; p++) begin
                bus.sdi = 1'($urandom_range(0, 1));
                sck_pulse();
            end
            wait_done("rand_done", lat);
            read_digest(got_d);
            check("rand_digest", got_d, exp_d);
            model_h = exp_d;

            for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom();
            exp_d = sha_ref(blk, model_h);
            send_block(blk, 1'b0);
            wait_done("chain_done", lat);
            check("chain_latency_in_range", (lat >= 64 && lat <= 72), 1'b1);
            read_digest(got_d);
            check("chain_digest", got_d, exp_d);
            model_h = exp_d;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
